glb_pe_set_scheduler: RTL and testbench

//  Sequences one convolution pass into glb_PE_SET: validates the kernel config, flushes the PEs,

---
 rtl/glb_pe_set_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_glb_pe_set_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_pe_set_scheduler.sv
// glb_pe_set_scheduler
//   Sequences one convolution pass into the PE set: checks the requested kernel
//   size, flushes the PEs, then forwards the global-buffer word stream onto the
//   shared PE bus with (row, col) destination tags. It finishes with a drain
//   window and a one-cycle done pulse.
//   Optional feature macro: SCHED_PERF_CNT_EN adds a saturating stall counter
//   output (stall_cnt).
module glb_pe_set_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 10,
    parameter int NUM_ROW    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int FLUSH_CYC  = 2,
    parameter int DRAIN_CYC  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [7:0]            kernel_size,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bus_valid,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [ID_WIDTH-1:0]   bus_row_id,
    output logic [ID_WIDTH-1:0]   bus_col_id,
    input  logic                  bus_ready,
    output logic                  pe_flush,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // One shared down-counter times both the flush and the drain windows, so
    // it is sized for the longer of the two.
    localparam int CNT_MAX = (FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0]    DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] COL_LAST   = ID_WIDTH'(NUM_COL - 1);
    localparam logic [ID_WIDTH-1:0] ID_ONE     = ID_WIDTH'(1);
    localparam logic [7:0]          KS_MAX     = 8'(NUM_ROW);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          ks_reg, ks_next;
    logic [ID_WIDTH-1:0] row_reg, row_next;
    logic [ID_WIDTH-1:0] col_reg, col_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                err_cfg_reg, err_cfg_next;

    logic cfg_bad;
    logic xfer;
    logic col_last;
    logic row_last;

    // A kernel of zero rows or more rows than the PE array has is rejected.
    assign cfg_bad  = (kernel_size == 8'd0) || (kernel_size > KS_MAX);
    // A word moves only while streaming and both sides agree.
    assign xfer     = (state_reg == ST_STREAM) && in_valid && bus_ready;
    assign col_last = (col_reg == COL_LAST);
    assign row_last = (8'(row_reg) == (ks_reg - 8'd1));

    // State, counters and latched kernel size.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            ks_reg      <= 8'd0;
            row_reg     <= '0;
            col_reg     <= '0;
            cnt_reg     <= '0;
            err_cfg_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ks_reg      <= ks_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            cnt_reg     <= cnt_next;
            err_cfg_reg <= err_cfg_next;
        end
    end

    // Next-state logic: pass sequencing and tag counter advance.
    always_comb begin
        state_next   = state_reg;
        ks_next      = ks_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        cnt_next     = cnt_reg;
        err_cfg_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_cfg_next = 1'b1;
                    end else begin
                        ks_next    = kernel_size;
                        cnt_next   = FLUSH_LOAD;
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_reg == '0) begin
                    state_next = ST_STREAM;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (col_last) begin
                        col_next = '0;
                        if (row_last) begin
                            // Final word of the pass: rewind tags for the next pass.
                            row_next   = '0;
                            cnt_next   = DRAIN_LOAD;
                            state_next = ST_DRAIN;
                        end else begin
                            row_next = row_reg + ID_ONE;
                        end
                    end else begin
                        col_next = col_reg + ID_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: the data path is a zero-latency pass-through while streaming.
    always_comb begin
        bus_valid = 1'b0;
        bus_data  = '0;
        in_ready  = 1'b0;
        pe_flush  = 1'b0;
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_DONE);
        err_cfg   = err_cfg_reg;
        case (state_reg)
            ST_FLUSH: begin
                pe_flush = 1'b1;
            end
            ST_STREAM: begin
                bus_valid = in_valid;
                bus_data  = in_data;
                in_ready  = bus_ready;
            end
            default: begin
            end
        endcase
    end

    // Tags come straight from the registered counters so they hold during stalls.
    assign bus_row_id = row_reg;
    assign bus_col_id = col_reg;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, stall_cnt_next;

    // Stall counter: counts stream cycles where a word waits on the PEs.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((state_reg == ST_IDLE) && start && !cfg_bad) begin
            stall_cnt_next = 32'd0;
        end else if ((state_reg == ST_STREAM) && in_valid && !bus_ready &&
                     (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_reg <= 32'd0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_glb_pe_set_scheduler.sv
// tb_glb_pe_set_scheduler
//   Directed bench for glb_pe_set_scheduler: normal pass, rejected configs,
//   bus stall, reset abort, ignored mid-pass start and back-to-back passes.
module tb_glb_pe_set_scheduler;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_COL    = 10;
    localparam int NUM_ROW    = 4;
    localparam int ID_WIDTH   = 4;

    logic                  clk;
    logic                  rstn;
    logic                  start;
    logic [7:0]            kernel_size;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  bus_valid;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [ID_WIDTH-1:0]   bus_row_id;
    logic [ID_WIDTH-1:0]   bus_col_id;
    logic                  bus_ready;
    logic                  pe_flush;
    logic                  busy;
    logic                  done;
    logic                  err_cfg;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    glb_pe_set_scheduler #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_COL    (NUM_COL),
        .NUM_ROW    (NUM_ROW),
        .ID_WIDTH   (ID_WIDTH),
        .FLUSH_CYC  (2),
        .DRAIN_CYC  (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .kernel_size (kernel_size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .bus_row_id  (bus_row_id),
        .bus_col_id  (bus_col_id),
        .bus_ready   (bus_ready),
        .pe_flush    (pe_flush),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg)
`ifdef SCHED_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Checks that every output sits at its reset value.
    task automatic check_idle_outputs(input string tag);
        check({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_pe_flush"},  32'(pe_flush),  32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err_cfg"},   32'(err_cfg),   32'd0);
        check({tag, "_row_id"},    32'(bus_row_id), 32'd0);
        check({tag, "_col_id"},    32'(bus_col_id), 32'd0);
        check({tag, "_bus_data"},  32'(bus_data),  32'd0);
`ifdef SCHED_PERF_CNT_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    // Rejected start: err_cfg must pulse exactly once, one cycle after start,
    // with no flush and busy never raised.
    task automatic cfg_err(input logic [7:0] ks);
        int err_n = 0;
        int err_cyc = -1;
        int busy_n = 0;
        int flush_n = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            start       = (cyc == 0);
            kernel_size = ks;
            in_valid    = 1'b1;
            bus_ready   = 1'b1;
            @(negedge clk);
            if (err_cfg) begin
                err_n++;
                err_cyc = cyc;
            end
            if (busy) busy_n++;
            if (pe_flush) flush_n++;
        end
        start = 1'b0;
        check("cfg_err_pulses", 32'(err_n), 32'd1);
        check("cfg_err_cycle",  32'(err_cyc), 32'd1);
        check("cfg_err_busy",   32'(busy_n), 32'd0);
        check("cfg_err_flush",  32'(flush_n), 32'd0);
        $display("cfg_err kernel_size=%0d err_pulses=%0d", ks, err_n);
    endtask

    // Runs one pass and checks flush length, tag order, data forwarding,
    // stall behaviour, drain length and done/busy timing.
    task automatic run_pass(input int ks, input int stall_idx, input int stall_len,
                            input int abort_at, input int midstart_at,
                            input bit pre_started, input bit chain, input int chain_ks);
        int  total = ks * NUM_COL;
        int  xfer = 0;
        int  flush_n = 0;
        int  flush_rdy_err = 0;
        int  tag_err = 0;
        int  data_err = 0;
        int  stall_n = 0;
        int  stall_tag_err = 0;
        int  done_n = 0;
        int  done_busy_err = 0;
        int  done_cyc = -1;
        int  last_edge = -1;
        int  busy_fall = -1;
        int  err_n = 0;
        int  stall_left = stall_len;
        bit  fin = 0;
        bit  aborted = 0;
        bit  chain_now = 0;
        bit  ms_done = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            kernel_size = 8'd0;
            if (cyc == 0 && !pre_started) begin
                start       = 1'b1;
                kernel_size = 8'(ks);
            end
            if (midstart_at >= 0 && xfer == midstart_at && !ms_done) begin
                start       = 1'b1;
                kernel_size = 8'd1;
                ms_done     = 1'b1;
            end
            if (chain_now) begin
                start       = 1'b1;
                kernel_size = 8'(chain_ks);
            end
            if (abort_at >= 0 && xfer == abort_at) begin
                rstn = 1'b0;
                #1;
                check_idle_outputs("abort");
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
                in_valid  = 1'b1;
                in_data   = 16'(16'h5A00 + xfer);
                bus_ready = !(xfer == stall_idx && stall_left > 0);
                if (!bus_ready) stall_left--;
                @(negedge clk);
                if (pe_flush) begin
                    flush_n++;
                    if (in_ready || bus_valid) flush_rdy_err++;
                end
                if (bus_valid && in_ready) begin
                    if (32'(bus_row_id) != 32'(xfer / NUM_COL) ||
                        32'(bus_col_id) != 32'(xfer % NUM_COL)) tag_err++;
                    if (bus_data !== in_data) data_err++;
                    if (xfer == total - 1) last_edge = cyc + 1;
                    xfer++;
                end else if (bus_valid && !in_ready) begin
                    stall_n++;
                    if (32'(bus_row_id) != 32'(xfer / NUM_COL) ||
                        32'(bus_col_id) != 32'(xfer % NUM_COL)) stall_tag_err++;
                end
                if (err_cfg) err_n++;
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                    if (!busy) done_busy_err++;
                    if (chain) chain_now = 1'b1;
                end
                if (done_n > 0 && !done && !busy) begin
                    busy_fall = cyc;
                    fin       = 1'b1;
                end
            end
        end
        check("pass_finished", 32'(fin), 32'd1);
        if (!aborted) begin
            check("flush_len",     32'(flush_n), 32'd2);
            check("flush_idle",    32'(flush_rdy_err), 32'd0);
            check("xfer_count",    32'(xfer), 32'(total));
            check("tag_order",     32'(tag_err), 32'd0);
            check("data_fwd",      32'(data_err), 32'd0);
            check("stall_cycles",  32'(stall_n), 32'(stall_len));
            check("stall_tags",    32'(stall_tag_err), 32'd0);
            check("done_pulses",   32'(done_n), 32'd1);
            check("done_busy",     32'(done_busy_err), 32'd0);
            // The last transfer completes on the edge closing its sample cycle.
            check("drain_len",     32'(done_cyc - last_edge), 32'd8);
            check("busy_fall",     32'(busy_fall - done_cyc), 32'd1);
            check("no_err_cfg",    32'(err_n), 32'd0);
`ifdef SCHED_PERF_CNT_EN
            check("stall_cnt",     stall_cnt, 32'(stall_len));
`endif
        end
        $display("pass ks=%0d xfers=%0d stalls=%0d aborted=%0d", ks, xfer, stall_n, aborted);
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        kernel_size = 8'd0;
        in_valid    = 1'b0;
        in_data     = '0;
        bus_ready   = 1'b0;

        // Reset state.
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Nominal ks=3 pass with no backpressure.
        run_pass(3, -1, 0, -1, -1, 1'b0, 1'b0, 0);

        // Illegal kernel sizes.
        cfg_err(8'd0);
        cfg_err(8'd5);

        // Three-cycle stall on word (1,4) of a ks=2 pass.
        run_pass(2, 14, 3, -1, -1, 1'b0, 1'b0, 0);

        // Reset abort at transfer 15, then a clean pass from (0,0).
        run_pass(3, -1, 0, 15, -1, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        run_pass(2, -1, 0, -1, -1, 1'b0, 1'b0, 0);

        // start pulsed mid-stream must not disturb the ks=3 pass.
        run_pass(3, -1, 0, -1, 5, 1'b0, 1'b0, 0);

        // Back-to-back: ks=4 pass, restart the cycle after done with ks=2.
        run_pass(4, -1, 0, -1, -1, 1'b0, 1'b1, 2);
        run_pass(2, -1, 0, -1, -1, 1'b1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
